prince_sbox_layer_fwd_serial: RTL
=================================

Name: prince_sbox_layer_fwd_serial

Overview:
- Serial, second-order masked forward PRINCE S-box layer over a 64-bit state held as 3 Boolean shares.
- Sits on the encryption datapath before the linear layer. Mirrors the parallel inverse layer used on the decryption side.
- Accepts a shared state via a valid/ready handshake and processes one nibble per cycle through a single instance of the existing forward masked S-box core (PRINCE_Sbox, 1-cycle registered, 3-share).
- Returns the substituted shared state via a valid/ready handshake.

Parameters:
- NIB, 16: nibbles per state; state width is 4*NIB.
- RAND_W, 108: fresh-randomness bits consumed per nibble issue.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_s1, in_s2, in_s3  in  4*NIB each  input shares.
- rnd  in  RAND_W  fresh randomness for the current issue.
- rnd_valid  in  1  rnd is fresh this cycle.
- out_valid  out  1  output shares valid.
- out_ready  in  1  consumer accepts the output.
- out_s1, out_s2, out_s3  out  4*NIB each  output shares.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high. Under reset: in_ready=0, out_valid=0, busy=0, out_s* = 0, all state and share registers 0, FSM = IDLE. After release: in_ready=1 on the first clock edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch all three shares into the state registers, clear nibble index issue_idx and capture index cap_idx to 0, go to RUN.
- RUN:
  - Each cycle with rnd_valid=1, drive the core with nibble issue_idx of each share.
  - Core randomness = rnd; core sel = issue_idx[0].
  - Core neighbour input = {share2, share1} of nibble (issue_idx+1) mod NIB, taken from the original latched state (not yet substituted).
  - Increment issue_idx.
  - When rnd_valid=0: no issue, issue_idx holds, and the pipeline valid bit for that slot is 0.
  - After issuing nibble NIB-1, go to DRAIN.
- Capture: a 1-bit pipeline valid follows each issue by exactly 1 cycle. When it is set, write the core's out1/out2/out3 into nibble cap_idx of a separate result buffer and increment cap_idx.
- DRAIN: wait for the final capture (cap_idx reaches NIB), then go to DONE.
- DONE:
  - out_valid=1 and out_s* = result buffer, held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE.
  - in_ready=1 again on the next cycle; no same-cycle turnaround.
- Latency with rnd_valid tied high and handshake at edge T:
  - Issues occur at edges T+1..T+16; captures at T+2..T+17.
  - out_valid is first visible after edge T+17, i.e. 18 cycles from acceptance.
  - Each rnd_valid=0 cycle during RUN adds exactly 1 cycle.
- Correctness: XOR of out shares = S(XOR of in shares) applied nibble-wise, with S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4. Nibble i is bits [4i+3:4i].
- Security: shares are never XORed together inside this block. Each issue uses a distinct rnd word: rnd is sampled only on cycles when an issue occurs.
- in_valid while busy: ignored (in_ready=0).
- rst mid-operation: the partial result is discarded and no out_valid is produced. The next state must be re-sent.
- index wrap: issue_idx and cap_idx are clog2(NIB)+1 bits wide; neighbour index NIB-1 wraps to 0.

Optional Feature:
- PRINCE_SBL_CLEAR_EN
- Defined: on the out_valid&out_ready handshake, the latched input-state registers and the result buffer are synchronously cleared to 0. out_s* reads 0 while not in DONE.
- Undefined: registers retain their last values and out_s* shows the result buffer at all times.

Test Plan:
- Functional mapping: in_s1=0x0123456789ABCDEF, in_s2=in_s3=0, rnd random, rnd_valid=1 -> out_s1^out_s2^out_s3 = 0xBF32AC916780E5D4; out_valid first seen 18 cycles after acceptance.
- Masked input: in_s2, in_s3 random with in_s1 = 0x0123456789ABCDEF ^ in_s2 ^ in_s3 -> same unshared result 0xBF32AC916780E5D4; no individual output share equals the unshared value across 100 random runs.
- Randomness stall: rnd_valid low on 5 separate cycles during RUN -> out_valid seen 23 cycles after acceptance, result unchanged.
- Output backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_s* stable throughout, in_ready=0; after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-run: assert rst 7 cycles after acceptance -> out_valid=0, busy=0, in_ready=1 after release; the next state completes correctly with 18-cycle latency.
- With PRINCE_SBL_CLEAR_EN defined -> out_s1=out_s2=out_s3=0 one cycle after the output handshake.

Source files
------------

// File: rtl/prince_sbox_layer_fwd_serial_if.sv
// rtl/prince_sbox_layer_fwd_serial_if.sv - handshake bundle for the serial masked PRINCE S-box layer
//
// Groups the input-state handshake, randomness feed, output-state handshake
// and busy flag of prince_sbox_layer_fwd_serial.
//   master : producer/consumer side (drives in_*, rnd*, out_ready)
//   slave  : the S-box layer itself (drives in_ready, out_*, busy)
interface prince_sbox_layer_fwd_serial_if #(
  parameter int NIB    = 16,
  parameter int RAND_W = 108
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NIB-1:0]  in_s1;
  logic [4*NIB-1:0]  in_s2;
  logic [4*NIB-1:0]  in_s3;
  logic [RAND_W-1:0] rnd;
  logic              rnd_valid;
  logic              out_valid;
  logic              out_ready;
  logic [4*NIB-1:0]  out_s1;
  logic [4*NIB-1:0]  out_s2;
  logic [4*NIB-1:0]  out_s3;
  logic              busy;

  modport master (
    output in_valid, in_s1, in_s2, in_s3, rnd, rnd_valid, out_ready,
    input  in_ready, out_valid, out_s1, out_s2, out_s3, busy
  );

  modport slave (
    input  in_valid, in_s1, in_s2, in_s3, rnd, rnd_valid, out_ready,
    output in_ready, out_valid, out_s1, out_s2, out_s3, busy
  );
endinterface

// File: rtl/prince_sbox_layer_fwd_serial.sv
// rtl/prince_sbox_layer_fwd_serial.sv - serial 3-share masked forward PRINCE S-box layer
//
// Accepts a 64-bit state as three Boolean shares, pushes one nibble per cycle
// through a single registered 3-share S-box core and returns the substituted
// shares. Shares are never recombined inside this block.
//
// Ports (prince_sbox_layer_fwd_serial):
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus (slave)    in_valid/in_ready/in_s1..3   input state handshake
//                  rnd/rnd_valid                 fresh randomness, one word per issue
//                  out_valid/out_ready/out_s1..3 output state handshake
//                  busy                          high whenever the FSM is not IDLE
//
// Optional build macro PRINCE_SBL_CLEAR_EN: the latched input state and the
// result buffer are zeroed on the output handshake, and out_s* reads 0 outside
// DONE. Without it the registers keep their contents and out_s* always shows
// the result buffer.

// PRINCE_Sbox - registered 3-share forward PRINCE S-box, one nibble per cycle
//
// Ports: clk, rst (async, active-high), en (load the register stage),
//   in1..in3 input shares, rnd fresh randomness, sel/nb remask steering and
//   neighbour-nibble shares, out1..out3 output shares (valid 1 cycle after en).
//
// Every cross-share product a_i*b_j*c_k of the S-box ANF is formed as its own
// term (27 share tuples x 4 bits), each term is remasked with a zero-sum ring
// mask and registered before any compression, so glitches cannot combine
// shares across the register.
module PRINCE_Sbox #(
  parameter int RAND_W = 108
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        in1,
  input  logic [3:0]        in2,
  input  logic [3:0]        in3,
  input  logic [RAND_W-1:0] rnd,
  input  logic              sel,
  input  logic [7:0]        nb,
  output logic [3:0]        out1,
  output logic [3:0]        out2,
  output logic [3:0]        out3
);
  // Entry x lives in bits [4x+3:4x]: S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4
  localparam logic [63:0] SBOX = 64'h4D5E087619CA23FB;
  localparam int NT = 27;

  // Algebraic normal form of each output bit: bit 16*b+mono is the
  // coefficient of the monomial whose variable set is the bit mask mono.
  function automatic logic [63:0] anf_calc();
    logic [63:0] r;
    logic [15:0] f;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int x = 0; x < 16; x++) f[x] = SBOX[4*x+b];
      for (int i = 0; i < 4; i++)
        for (int x = 0; x < 16; x++)
          if (((x >> i) & 1) != 0) f[x] = f[x] ^ f[x ^ (1 << i)];
      r[16*b +: 16] = f;
    end
    return r;
  endfunction

  localparam logic [63:0] ANF = anf_calc();

  // Contribution of share tuple (i,j,k): the first variable of each monomial
  // takes share i, the second share j, the third share k. Lower-degree
  // monomials only appear in tuples whose unused positions are share 0, so
  // summing all 27 tuples reproduces the unshared function exactly.
  function automatic logic [3:0] dterm(input int i, input int j, input int k,
                                       input logic [11:0] xs);
    logic [3:0] acc;
    logic       prod;
    int         p;
    int         sh;
    acc = '0;
    for (int b = 0; b < 4; b++) begin
      for (int mono = 0; mono < 16; mono++) begin
        if (ANF[16*b+mono]) begin
          p    = 0;
          prod = 1'b1;
          for (int v = 0; v < 4; v++) begin
            if (((mono >> v) & 1) != 0) begin
              sh   = (p == 0) ? i : ((p == 1) ? j : k);
              prod = prod & xs[4*sh+v];
              p    = p + 1;
            end
          end
          if ((p == 0 && i == 0 && j == 0 && k == 0) ||
              (p == 1 && j == 0 && k == 0) ||
              (p == 2 && k == 0) || (p == 3))
            acc[b] = acc[b] ^ prod;
        end
      end
    end
    return acc;
  endfunction

  logic [RAND_W-1:0] rmix;
  logic [3:0]        term_d [NT];
  logic [3:0]        term_q [NT];

  // Neighbour shares are folded into the mask source; the ring construction
  // below cancels whatever the source is, so correctness never depends on it.
  always_comb begin
    rmix = rnd;
    if (sel) rmix[RAND_W-1 -: 8] = rmix[RAND_W-1 -: 8] ^ nb;
    else     rmix[7:0]           = rmix[7:0] ^ nb;
  end

  // Term t is masked with chunk t XOR chunk t+1 (mod 27): the masks sum to 0.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      term_d[t] = dterm(t % 3, (t / 3) % 3, t / 9, {in3, in2, in1});
      for (int b = 0; b < 4; b++)
        term_d[t][b] = term_d[t][b] ^ rmix[(4*t+b) % RAND_W]
                                    ^ rmix[(4*((t+1) % NT)+b) % RAND_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) term_q[t] <= '0;
    end else if (en) begin
      for (int t = 0; t < NT; t++) term_q[t] <= term_d[t];
    end
  end

  // Compression happens only after the register stage.
  always_comb begin
    out1 = '0;
    out2 = '0;
    out3 = '0;
    for (int t = 0; t < NT; t++) begin
      if (t < 9)       out1 = out1 ^ term_q[t];
      else if (t < 18) out2 = out2 ^ term_q[t];
      else             out3 = out3 ^ term_q[t];
    end
  end
endmodule

module prince_sbox_layer_fwd_serial #(
  parameter int NIB    = 16,
  parameter int RAND_W = 108
) (
  input  logic                           clk,
  input  logic                           rst,
  prince_sbox_layer_fwd_serial_if.slave  bus
);
  localparam int W  = 4*NIB;
  localparam int IW = $clog2(NIB);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(NIB-1);
  localparam logic [CW-1:0] FULL = CW'(NIB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            live_q;
  logic [W-1:0]    st1_q, st2_q, st3_q;
  logic [W-1:0]    res1_q, res2_q, res3_q;
  logic [CW-1:0]   issue_idx_q, cap_idx_q;
  logic            pipe_v_q;

  logic            accept, issue, out_hs;
  logic            in_ready_c, out_valid_c, busy_c;
  logic [IW-1:0]   iss_n, nbr_n, cap_n;
  logic [3:0]      c_in1, c_in2, c_in3;
  logic [3:0]      c_o1, c_o2, c_o3;
  logic [7:0]      c_nb;

  // Nibble selection; the neighbour always comes from the latched (not yet
  // substituted) state and wraps NIB-1 -> 0.
  always_comb begin
    iss_n = issue_idx_q[IW-1:0];
    cap_n = cap_idx_q[IW-1:0];
    nbr_n = (iss_n == IW'(NIB-1)) ? '0 : iss_n + 1'b1;
    c_in1 = st1_q[{iss_n, 2'b00} +: 4];
    c_in2 = st2_q[{iss_n, 2'b00} +: 4];
    c_in3 = st3_q[{iss_n, 2'b00} +: 4];
    c_nb  = {st2_q[{nbr_n, 2'b00} +: 4], st1_q[{nbr_n, 2'b00} +: 4]};
  end

  PRINCE_Sbox #(.RAND_W(RAND_W)) u_sbox (
    .clk  (clk),
    .rst  (rst),
    .en   (issue),
    .in1  (c_in1),
    .in2  (c_in2),
    .in3  (c_in3),
    .rnd  (bus.rnd),
    .sel  (iss_n[0]),
    .nb   (c_nb),
    .out1 (c_o1),
    .out2 (c_o2),
    .out3 (c_o3)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = (state_q != S_IDLE);
    accept      = 1'b0;
    issue       = 1'b0;
    out_hs      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // live_q keeps in_ready low until the first edge after reset.
        in_ready_c = live_q;
        accept     = bus.in_valid & live_q;
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        issue = bus.rnd_valid;
        if (issue && issue_idx_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the edge that performs the final capture.
        if (cap_idx_q == FULL || (pipe_v_q && cap_idx_q == LAST))
          state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        out_hs      = bus.out_ready;
        if (out_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      st1_q       <= '0;
      st2_q       <= '0;
      st3_q       <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      res3_q      <= '0;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      pipe_v_q    <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      state_q  <= state_d;
      pipe_v_q <= issue;
      if (accept) begin
        st1_q       <= bus.in_s1;
        st2_q       <= bus.in_s2;
        st3_q       <= bus.in_s3;
        issue_idx_q <= '0;
        cap_idx_q   <= '0;
      end
      if (issue) issue_idx_q <= issue_idx_q + 1'b1;
      if (pipe_v_q) begin
        res1_q[{cap_n, 2'b00} +: 4] <= c_o1;
        res2_q[{cap_n, 2'b00} +: 4] <= c_o2;
        res3_q[{cap_n, 2'b00} +: 4] <= c_o3;
        cap_idx_q <= cap_idx_q + 1'b1;
      end
`ifdef PRINCE_SBL_CLEAR_EN
      if (out_hs) begin
        st1_q  <= '0;
        st2_q  <= '0;
        st3_q  <= '0;
        res1_q <= '0;
        res2_q <= '0;
        res3_q <= '0;
      end
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
`ifdef PRINCE_SBL_CLEAR_EN
  assign bus.out_s1 = (state_q == S_DONE) ? res1_q : '0;
  assign bus.out_s2 = (state_q == S_DONE) ? res2_q : '0;
  assign bus.out_s3 = (state_q == S_DONE) ? res3_q : '0;
`else
  assign bus.out_s1 = res1_q;
  assign bus.out_s2 = res2_q;
  assign bus.out_s3 = res3_q;
`endif
endmodule
